// File: rtl/segre_store_buffer.sv
// segre_store_buffer: circular store buffer between MEM stage and data cache,
// with youngest-match load forwarding and an IDLE/WRITE/FLUSH drain FSM.
module segre_store_buffer #(
    parameter int NUM_ENTRIES = 4,
    parameter int WORD_SIZE   = 32,
    parameter int ADDR_WIDTH  = WORD_SIZE
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           push_valid_i,
    input  logic [ADDR_WIDTH-1:0]          push_addr_i,
    input  logic [31:0]                    push_data_i,
    input  logic [3:0]                     push_be_i,
    input  logic                           ld_valid_i,
    input  logic [ADDR_WIDTH-1:0]          ld_addr_i,
    input  logic [3:0]                     ld_be_i,
    output logic                           ld_hit_o,
    output logic [31:0]                    ld_data_o,
    input  logic                           dc_port_free_i,
    output logic                           dc_wr_o,
    output logic [ADDR_WIDTH-1:0]          dc_wr_addr_o,
    output logic [31:0]                    dc_wr_data_o,
    output logic [3:0]                     dc_wr_be_o,
    input  logic                           dc_wr_ack_i,
    input  logic                           flush_i,
    output logic                           store_buffer_draining_o,
    output logic                           full_o,
    output logic                           empty_o,
    output logic [$clog2(NUM_ENTRIES):0]   count_o
);
    localparam int PW = $clog2(NUM_ENTRIES);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {IDLE, WRITE, FLUSH} state_t;

    state_t                  r_state, w_state_next;
    logic [ADDR_WIDTH-1:0]   r_addr [NUM_ENTRIES];
    logic [31:0]             r_data [NUM_ENTRIES];
    logic [3:0]              r_be   [NUM_ENTRIES];
    logic [NUM_ENTRIES-1:0]  r_valid;
    logic [PW-1:0]           r_head, r_tail;
    logic [CW-1:0]           r_count;

    logic          w_match_found, w_cover, w_fwd, w_conflict, w_push, w_ack, w_unused;
    logic [PW-1:0] w_match_idx;
    logic [31:0]   w_mask;

    assign w_unused = &{1'b0, ld_addr_i[1:0]};

    // Valid entries are contiguous from head, so scanning oldest to youngest leaves the youngest match.
    always_comb begin
        w_match_found = 1'b0;
        w_match_idx   = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (r_valid[r_head + PW'(i)] &&
                r_addr[r_head + PW'(i)][ADDR_WIDTH-1:2] == ld_addr_i[ADDR_WIDTH-1:2]) begin
                w_match_found = 1'b1;
                w_match_idx   = r_head + PW'(i);
            end
        end
    end

    assign w_mask     = {{8{ld_be_i[3]}}, {8{ld_be_i[2]}}, {8{ld_be_i[1]}}, {8{ld_be_i[0]}}};
    assign w_cover    = (ld_be_i & ~r_be[w_match_idx]) == 4'b0;
    assign w_fwd      = ld_valid_i && w_match_found;
    assign w_conflict = w_fwd && !w_cover;
    assign ld_hit_o   = w_fwd && w_cover;
    assign ld_data_o  = ld_hit_o ? (r_data[w_match_idx] & w_mask) : 32'h0;

    assign full_o  = r_count == CW'(NUM_ENTRIES);
    assign empty_o = r_count == '0;
    assign count_o = r_count;

    assign store_buffer_draining_o = (push_valid_i && full_o) || w_conflict || (r_state == FLUSH);
    assign w_push = push_valid_i && !full_o && !store_buffer_draining_o;

    assign dc_wr_o      = (r_state != IDLE) && !empty_o;
    assign dc_wr_addr_o = r_addr[r_head];
    assign dc_wr_data_o = r_data[r_head];
    assign dc_wr_be_o   = r_be[r_head];
    assign w_ack        = dc_wr_o && dc_wr_ack_i;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    w_state_next = (flush_i && !empty_o) ? FLUSH :
                                    (!empty_o && dc_port_free_i) ? WRITE : IDLE;
            WRITE:   w_state_next = w_ack ? IDLE : WRITE;
            FLUSH:   w_state_next = (empty_o || (w_ack && r_count == CW'(1))) ? IDLE : FLUSH;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= IDLE;
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_valid <= '0;
        end else begin
            r_state <= w_state_next;
            r_count <= r_count + CW'(w_push) - CW'(w_ack);
            if (w_push) begin
                r_addr[r_tail]  <= push_addr_i;
                r_data[r_tail]  <= push_data_i;
                r_be[r_tail]    <= push_be_i;
                r_valid[r_tail] <= 1'b1;
                r_tail          <= r_tail + 1'b1;
            end
            if (w_ack) begin
                r_valid[r_head] <= 1'b0;
                r_head          <= r_head + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_segre_store_buffer.sv
// tb_segre_store_buffer: queue-based reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_segre_store_buffer;
    localparam int N  = 4;
    localparam int AW = 32;

    logic          clk_i = 1'b0, rst_i = 1'b1;
    logic          push_valid_i = 0, ld_valid_i = 0, dc_port_free_i = 0, dc_wr_ack_i = 0, flush_i = 0;
    logic [AW-1:0] push_addr_i = 0, ld_addr_i = 0;
    logic [31:0]   push_data_i = 0;
    logic [3:0]    push_be_i = 0, ld_be_i = 0;
    logic          ld_hit_o, dc_wr_o, store_buffer_draining_o, full_o, empty_o;
    logic [31:0]   ld_data_o, dc_wr_data_o;
    logic [AW-1:0] dc_wr_addr_o;
    logic [3:0]    dc_wr_be_o;
    logic [2:0]    count_o;

    segre_store_buffer #(.NUM_ENTRIES(N), .ADDR_WIDTH(AW)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .push_valid_i(push_valid_i), .push_addr_i(push_addr_i), .push_data_i(push_data_i), .push_be_i(push_be_i),
        .ld_valid_i(ld_valid_i), .ld_addr_i(ld_addr_i), .ld_be_i(ld_be_i),
        .ld_hit_o(ld_hit_o), .ld_data_o(ld_data_o),
        .dc_port_free_i(dc_port_free_i), .dc_wr_o(dc_wr_o), .dc_wr_addr_o(dc_wr_addr_o),
        .dc_wr_data_o(dc_wr_data_o), .dc_wr_be_o(dc_wr_be_o), .dc_wr_ack_i(dc_wr_ack_i),
        .flush_i(flush_i), .store_buffer_draining_o(store_buffer_draining_o),
        .full_o(full_o), .empty_o(empty_o), .count_o(count_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {logic [31:0] a; logic [31:0] d; logic [3:0] be;} ent_t;
    ent_t q[$];
    int   mst = 0;
    int   n_chk = 0, n_fail = 0;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endfunction

    // Reference model: queue of stores, drain mode 0=idle 1=single write 2=flush.
    always @(negedge clk_i) begin
        int m, sz;
        logic full, hit, conf, drn, wr, ack, psh;
        logic [31:0] ed, mask;
        if (rst_i) begin
            q.delete();
            mst = 0;
        end else begin
            sz   = q.size();
            full = (sz == N);
            m    = -1;
            for (int i = sz - 1; i >= 0; i--)
                if (m < 0 && q[i].a[31:2] == ld_addr_i[31:2]) m = i;
            mask = {{8{ld_be_i[3]}}, {8{ld_be_i[2]}}, {8{ld_be_i[1]}}, {8{ld_be_i[0]}}};
            hit = 0; conf = 0; ed = 0;
            if (ld_valid_i && m >= 0) begin
                if ((ld_be_i & ~q[m].be) == 4'b0) begin
                    hit = 1;
                    ed  = q[m].d & mask;
                end else conf = 1;
            end
            drn = (push_valid_i && full) || conf || (mst == 2);
            wr  = (mst != 0) && sz > 0;
            chk("count", 32'(count_o), 32'(sz));
            chk("full", 32'(full_o), 32'(full));
            chk("empty", 32'(empty_o), 32'(sz == 0));
            chk("ld_hit", 32'(ld_hit_o), 32'(hit));
            chk("ld_data", ld_data_o, ed);
            chk("draining", 32'(store_buffer_draining_o), 32'(drn));
            chk("dc_wr", 32'(dc_wr_o), 32'(wr));
            if (wr) begin
                chk("wr_addr", dc_wr_addr_o, q[0].a);
                chk("wr_data", dc_wr_data_o, q[0].d);
                chk("wr_be", 32'(dc_wr_be_o), 32'(q[0].be));
            end
            ack = wr && dc_wr_ack_i;
            psh = push_valid_i && !full && !drn;
            if (mst == 0) mst = (flush_i && sz > 0) ? 2 : (sz > 0 && dc_port_free_i) ? 1 : 0;
            else if (mst == 1) mst = ack ? 0 : 1;
            else if (sz == 0 || (ack && sz == 1)) mst = 0;
            if (ack) void'(q.pop_front());
            if (psh) q.push_back('{push_addr_i, push_data_i, push_be_i});
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_in();
        push_valid_i = 0; ld_valid_i = 0; dc_port_free_i = 0; dc_wr_ack_i = 0; flush_i = 0;
    endtask

    task automatic push(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        push_valid_i = 1; push_addr_i = a; push_data_i = d; push_be_i = be;
        tick();
        push_valid_i = 0;
    endtask

    task automatic drain_all();
        dc_port_free_i = 1; dc_wr_ack_i = 1;
        for (int i = 0; i < 40 && !empty_o; i++) tick();
        chk("drain_empty", 32'(empty_o), 32'd1);
        idle_in();
        tick();
    endtask

    initial begin
        int k;
        logic [31:0] exp_a [3];
        repeat (2) tick();
        rst_i = 0;
        @(negedge clk_i);
        chk("rst_dc_wr", 32'(dc_wr_o), 0);
        chk("rst_empty", 32'(empty_o), 1);
        chk("rst_full", 32'(full_o), 0);
        chk("rst_drain", 32'(store_buffer_draining_o), 0);
        chk("rst_hit", 32'(ld_hit_o), 0);
        tick();

        push(32'h100, 32'hAABBCCDD, 4'hF);
        ld_valid_i = 1; ld_addr_i = 32'h100; ld_be_i = 4'hF;
        @(negedge clk_i);
        chk("fwd_hit", 32'(ld_hit_o), 1);
        chk("fwd_data", ld_data_o, 32'hAABBCCDD);
        ld_be_i = 4'h6;
        @(negedge clk_i);
        chk("fwd_mask", ld_data_o, 32'h00BBCC00);
        idle_in();
        drain_all();

        for (int i = 0; i < N; i++) push(32'h400 + 32'(4 * i), 32'h1000 + 32'(i), 4'hF);
        push_valid_i = 1; push_addr_i = 32'h410; push_data_i = 32'hDEAD; push_be_i = 4'hF;
        @(negedge clk_i);
        chk("full_full", 32'(full_o), 1);
        chk("full_drain", 32'(store_buffer_draining_o), 1);
        chk("full_count", 32'(count_o), 4);
        tick();
        chk("full_noacc", 32'(count_o), 4);
        dc_port_free_i = 1; dc_wr_ack_i = 1;
        repeat (4) tick();
        push_valid_i = 0;
        drain_all();

        push(32'h200, 32'h11, 4'h1);
        ld_valid_i = 1; ld_addr_i = 32'h200; ld_be_i = 4'hF;
        @(negedge clk_i);
        chk("part_hit", 32'(ld_hit_o), 0);
        chk("part_drain", 32'(store_buffer_draining_o), 1);
        dc_port_free_i = 1; dc_wr_ack_i = 1;
        for (int i = 0; i < 20 && count_o != 0; i++) tick();
        @(negedge clk_i);
        chk("part_count", 32'(count_o), 0);
        chk("part_release", 32'(store_buffer_draining_o), 0);
        idle_in();
        tick();

        push(32'h300, 32'h1, 4'hF);
        push(32'h300, 32'h2, 4'hF);
        ld_valid_i = 1; ld_addr_i = 32'h300; ld_be_i = 4'hF;
        @(negedge clk_i);
        chk("young_hit", 32'(ld_hit_o), 1);
        chk("young_data", ld_data_o, 32'h2);
        idle_in();
        drain_all();

        for (int i = 0; i < 3; i++) begin
            exp_a[i] = 32'h500 + 32'(4 * i);
            push(exp_a[i], 32'h5000 + 32'(i), 4'hF);
        end
        flush_i = 1; dc_wr_ack_i = 1;
        k = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_i);
            if (dc_wr_o) begin
                chk("flush_drain", 32'(store_buffer_draining_o), 1);
                if (k < 3) chk("flush_order", dc_wr_addr_o, exp_a[k]);
                k++;
            end
            if (empty_o) break;
            tick();
        end
        chk("flush_writes", 32'(k), 3);
        tick();
        @(negedge clk_i);
        chk("flush_idle_wr", 32'(dc_wr_o), 0);
        chk("flush_empty", 32'(empty_o), 1);
        idle_in();
        tick();

        push(32'h600, 32'h66, 4'hF);
        dc_port_free_i = 1;
        tick();
        @(negedge clk_i);
        chk("midw_wr", 32'(dc_wr_o), 1);
        rst_i = 1;
        tick();
        rst_i = 0; idle_in();
        @(negedge clk_i);
        chk("midw_rst_wr", 32'(dc_wr_o), 0);
        chk("midw_rst_count", 32'(count_o), 0);
        chk("midw_rst_empty", 32'(empty_o), 1);
        tick();

        for (int c = 0; c < 3000; c++) begin
            rst_i          = ($urandom_range(0, 199) == 0);
            push_valid_i   = $urandom_range(0, 1);
            push_addr_i    = 32'(4 * $urandom_range(0, 7)) + 32'($urandom_range(0, 3));
            push_data_i    = $urandom;
            push_be_i      = 4'($urandom_range(1, 15));
            ld_valid_i     = $urandom_range(0, 1);
            ld_addr_i      = 32'(4 * $urandom_range(0, 7)) + 32'($urandom_range(0, 3));
            ld_be_i        = 4'($urandom_range(1, 15));
            dc_port_free_i = $urandom_range(0, 1);
            dc_wr_ack_i    = $urandom_range(0, 2) != 0;
            flush_i        = ($urandom_range(0, 19) == 0);
            tick();
        end
        rst_i = 0;
        idle_in();
        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish, %0d failures so far", n_fail);
        $fatal(1, "timeout");
    end
endmodule
